// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// One word per valid/ready handshake; tx, busy, tx_ready and done are all registered.
module uart_tx_param #(
  parameter int unsigned CLK_FREQ  = 12000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_done;

  state_t               w_state_nx;
  logic [CNT_W-1:0]     w_cnt_nx;
  logic [IDX_W-1:0]     w_idx_nx;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic                 w_par_nx;
  logic                 w_tx_nx;
  logic                 w_done_nx;
  logic                 w_bit_end;

  assign w_bit_end = (r_cnt == CNT_LAST);

  // Next state, then registered outputs derived from the next state so they align with it
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CNT_W'(1);
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_tx_nx    = 1'b1;
    w_done_nx  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        w_idx_nx = '0;
        if (tx_valid) begin
          w_shift_nx = tx_data;
          w_par_nx   = (^tx_data) ^ PAR_ODD;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_shift_nx = r_shift >> 1;
          if (r_idx == DATA_LAST) begin
            w_idx_nx   = '0;
            w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_nx = r_idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nx = '0;
          if (r_idx == STOP_LAST) begin
            w_idx_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_idx_nx = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_idx_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase

    case (w_state_nx)
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = w_shift_nx[0];
      S_PARITY: w_tx_nx = w_par_nx;
      default:  w_tx_nx = 1'b1;
    endcase

    w_done_nx = (w_state_nx == S_STOP) && (w_cnt_nx == CNT_LAST) && (w_idx_nx == STOP_LAST);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_par   <= w_par_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_ready <= (w_state_nx == S_IDLE);
      r_done  <= w_done_nx;
    end
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign tx_ready = r_ready;
  assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: six instances cover default 8N1, parity, 7N2 back-to-back,
// mid-frame reset and the minimum divider. Expected frames are hand-written, first line bit at bit 0.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]      nrst_v;
  logic [5:0]      valid_v;
  logic [5:0][7:0] data_v;
  logic [5:0]      tx_w;
  logic [5:0]      rdy_w;
  logic [5:0]      busy_w;
  logic [5:0]      done_w;

  int checks = 0;
  int passed = 0;

  uart_tx_param u0 (
    .clk(clk), .nrst(nrst_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_param #(.CLK_FREQ(160), .BAUD(10), .PARITY(2)) u1 (
    .clk(clk), .nrst(nrst_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_param #(.CLK_FREQ(160), .BAUD(10), .PARITY(1)) u2 (
    .clk(clk), .nrst(nrst_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_param #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .nrst(nrst_v[3]), .tx_data(data_v[3][6:0]), .tx_valid(valid_v[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));
  uart_tx_param #(.CLK_FREQ(160), .BAUD(10)) u4 (
    .clk(clk), .nrst(nrst_v[4]), .tx_data(data_v[4]), .tx_valid(valid_v[4]),
    .tx_ready(rdy_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .done(done_w[4]));
  uart_tx_param #(.CLK_FREQ(50), .BAUD(20)) u5 (
    .clk(clk), .nrst(nrst_v[5]), .tx_data(data_v[5]), .tx_valid(valid_v[5]),
    .tx_ready(rdy_w[5]), .tx(tx_w[5]), .busy(busy_w[5]), .done(done_w[5]));

  // Observe nb line bits of div clocks each, starting at the current negedge; unstable bits read as x
  task automatic capture_frame(input int inst, input int div, input int nb,
                               output logic [15:0] obs, output int dcnt, output int dat);
    logic v;
    obs  = '0;
    dcnt = 0;
    dat  = -1;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < div; c++) begin
        v = tx_w[inst];
        if (c == 0) obs[b] = v;
        else if (v !== obs[b]) obs[b] = 1'bx;
        if (done_w[inst] === 1'b1) begin
          dcnt++;
          dat = b * div + c;
        end
        @(negedge clk);
      end
    end
  endtask

  // Present one word at a negedge; returns at the first negedge after the accepting edge
  task automatic handshake(input int inst, input logic [7:0] d, input logic keep_valid);
    @(negedge clk);
    data_v[inst]  = d;
    valid_v[inst] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_v[inst] = keep_valid;
  endtask

  task automatic test_reset;
    int bad;
    nrst_v  = '0;
    valid_v = '0;
    data_v  = '0;
    repeat (5) @(negedge clk);
    checks++; if (tx_w !== 6'h3F) $display("FAIL reset_tx got %b exp 111111", tx_w); else passed++;
    checks++; if (rdy_w !== 6'h3F) $display("FAIL reset_ready got %b exp 111111", rdy_w); else passed++;
    checks++; if (busy_w !== 6'h00) $display("FAIL reset_busy got %b exp 000000", busy_w); else passed++;
    checks++; if (done_w !== 6'h00) $display("FAIL reset_done got %b exp 000000", done_w); else passed++;
    nrst_v = '1;
    bad = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL idle_20000 got %0d non-idle cycles exp 0", bad); else passed++;
  endtask

  task automatic test_default_8n1;
    logic [15:0] obs;
    logic [15:0] exp_f;
    int dcnt, dat;
    exp_f = 16'({1'b1, 8'h54, 1'b0});
    handshake(0, 8'h54, 1'b0);
    checks++;
    if (busy_w[0] !== 1'b1 || rdy_w[0] !== 1'b0)
      $display("FAIL 8n1_accept got busy=%b ready=%b exp busy=1 ready=0", busy_w[0], rdy_w[0]);
    else passed++;
    capture_frame(0, 1250, 10, obs, dcnt, dat);
    checks++; if (obs !== exp_f) $display("FAIL 8n1_frame got %b exp %b", obs, exp_f); else passed++;
    checks++;
    if (dcnt !== 1 || dat !== 12499) $display("FAIL 8n1_done got count=%0d at=%0d exp count=1 at=12499", dcnt, dat);
    else passed++;
    checks++;
    if (rdy_w[0] !== 1'b1 || tx_w[0] !== 1'b1 || done_w[0] !== 1'b0)
      $display("FAIL 8n1_after got ready=%b tx=%b done=%b exp 1 1 0", rdy_w[0], tx_w[0], done_w[0]);
    else passed++;
  endtask

  task automatic test_parity;
    logic [15:0] obs;
    logic [15:0] exp_f;
    int dcnt, dat;
    exp_f = 16'({1'b1, 1'b1, 8'h54, 1'b0});
    handshake(1, 8'h54, 1'b0);
    capture_frame(1, 16, 11, obs, dcnt, dat);
    checks++; if (obs !== exp_f) $display("FAIL even_frame got %b exp %b", obs, exp_f); else passed++;
    checks++;
    if (dcnt !== 1 || dat !== 175) $display("FAIL even_done got count=%0d at=%0d exp count=1 at=175", dcnt, dat);
    else passed++;
    exp_f = 16'({1'b1, 1'b0, 8'h54, 1'b0});
    handshake(2, 8'h54, 1'b0);
    capture_frame(2, 16, 11, obs, dcnt, dat);
    checks++; if (obs !== exp_f) $display("FAIL odd_frame got %b exp %b", obs, exp_f); else passed++;
    checks++;
    if (dcnt !== 1 || dat !== 175) $display("FAIL odd_done got count=%0d at=%0d exp count=1 at=175", dcnt, dat);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] obs;
    logic [15:0] exp_f;
    int dcnt, dat;
    exp_f = 16'({2'b11, 7'h41, 1'b0});
    handshake(3, 8'h41, 1'b1);
    fork
      capture_frame(3, 16, 10, obs, dcnt, dat);
      begin
        repeat (40) @(negedge clk);
        data_v[3] = 8'h00;
        repeat (60) @(negedge clk);
        data_v[3] = 8'h7F;
      end
    join
    checks++; if (obs !== exp_f) $display("FAIL b2b_frame1 got %b exp %b", obs, exp_f); else passed++;
    checks++;
    if (dcnt !== 1 || dat !== 159) $display("FAIL b2b_done1 got count=%0d at=%0d exp count=1 at=159", dcnt, dat);
    else passed++;
    checks++;
    if (tx_w[3] !== 1'b1 || rdy_w[3] !== 1'b1 || busy_w[3] !== 1'b0)
      $display("FAIL b2b_gap got tx=%b ready=%b busy=%b exp 1 1 0", tx_w[3], rdy_w[3], busy_w[3]);
    else passed++;
    @(negedge clk);
    valid_v[3] = 1'b0;
    checks++;
    if (busy_w[3] !== 1'b1 || tx_w[3] !== 1'b0)
      $display("FAIL b2b_start2 got busy=%b tx=%b exp busy=1 tx=0", busy_w[3], tx_w[3]);
    else passed++;
    exp_f = 16'({2'b11, 7'h7F, 1'b0});
    fork
      capture_frame(3, 16, 10, obs, dcnt, dat);
      begin
        repeat (40) @(negedge clk);
        data_v[3] = 8'h00;
      end
    join
    checks++; if (obs !== exp_f) $display("FAIL b2b_frame2 got %b exp %b", obs, exp_f); else passed++;
    checks++;
    if (dcnt !== 1 || dat !== 159) $display("FAIL b2b_done2 got count=%0d at=%0d exp count=1 at=159", dcnt, dat);
    else passed++;
    repeat (5) @(negedge clk);
    checks++;
    if (busy_w[3] !== 1'b0 || tx_w[3] !== 1'b1)
      $display("FAIL b2b_idle got busy=%b tx=%b exp busy=0 tx=1", busy_w[3], tx_w[3]);
    else passed++;
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] obs;
    logic [15:0] exp_f;
    int dcnt, dat, nd;
    handshake(4, 8'hA5, 1'b0);
    nd = 0;
    for (int k = 0; k < 70; k++) begin
      if (done_w[4] === 1'b1) nd++;
      @(negedge clk);
    end
    checks++; if (tx_w[4] !== 1'b0) $display("FAIL abort_bit3 got %b exp 0", tx_w[4]); else passed++;
    nrst_v[4] = 1'b0;
    #1;
    checks++;
    if (tx_w[4] !== 1'b1 || rdy_w[4] !== 1'b1 || busy_w[4] !== 1'b0)
      $display("FAIL abort_async got tx=%b ready=%b busy=%b exp 1 1 0", tx_w[4], rdy_w[4], busy_w[4]);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_w[4] === 1'b1) nd++;
    end
    nrst_v[4] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_w[4] === 1'b1) nd++;
    end
    checks++; if (nd !== 0) $display("FAIL abort_no_done got %0d done cycles exp 0", nd); else passed++;
    exp_f = 16'({1'b1, 8'hA5, 1'b0});
    handshake(4, 8'hA5, 1'b0);
    capture_frame(4, 16, 10, obs, dcnt, dat);
    checks++; if (obs !== exp_f) $display("FAIL abort_resend got %b exp %b", obs, exp_f); else passed++;
    checks++;
    if (dcnt !== 1 || dat !== 159) $display("FAIL abort_resend_done got count=%0d at=%0d exp count=1 at=159", dcnt, dat);
    else passed++;
  endtask

  task automatic test_min_div;
    logic [15:0] obs;
    logic [15:0] exp_f;
    int dcnt, dat;
    exp_f = 16'({1'b1, 8'h3C, 1'b0});
    handshake(5, 8'h3C, 1'b0);
    capture_frame(5, 2, 10, obs, dcnt, dat);
    checks++; if (obs !== exp_f) $display("FAIL div2_frame got %b exp %b", obs, exp_f); else passed++;
    checks++;
    if (dcnt !== 1 || dat !== 19) $display("FAIL div2_done got count=%0d at=%0d exp count=1 at=19", dcnt, dat);
    else passed++;
    checks++;
    if (rdy_w[5] !== 1'b1 || tx_w[5] !== 1'b1)
      $display("FAIL div2_after got ready=%b tx=%b exp 1 1", rdy_w[5], tx_w[5]);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_default_8n1;
    test_parity;
    test_back_to_back;
    test_reset_mid_frame;
    test_min_div;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
